// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel/line counters with sync, visibility and start pulses.
// Every output is registered from the next-state counters, so all describe the same pixel.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic        h_sinc,
  output logic        v_sinc,
  output logic [10:0] countH,
  output logic [10:0] countV,
  output logic        visible,
  output logic        line_start,
  output logic        frame_start
);

  localparam logic [10:0] H_LAST     = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_LAST     = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic        SYNC_ACT   = 1'(SYNC_POL);

  logic [10:0] next_h_s;
  logic [10:0] next_v_s;
  logic        line_s;
  logic        frame_s;
  logic        h_act_s;
  logic        v_act_s;
  logic        vis_s;

  // Next pixel position and the start pulses produced by this strobe
  always_comb begin
    next_h_s = countH;
    next_v_s = countV;
    line_s   = 1'b0;
    frame_s  = 1'b0;
    if (pix_en) begin
      if (countH == H_LAST) begin
        next_h_s = 11'd0;
        line_s   = 1'b1;
        if (countV == V_LAST) begin
          next_v_s = 11'd0;
          frame_s  = 1'b1;
        end else begin
          next_v_s = countV + 11'd1;
        end
      end else begin
        next_h_s = countH + 11'd1;
      end
    end else begin
      next_h_s = countH;
      next_v_s = countV;
    end
  end

  // Sync windows and visible area decoded from the next position
  always_comb begin
    h_act_s = (next_h_s >= H_SYNC_BEG) && (next_h_s <= H_SYNC_END);
    v_act_s = (next_v_s >= V_SYNC_BEG) && (next_v_s <= V_SYNC_END);
    vis_s   = (next_h_s < H_VIS) && (next_v_s < V_VIS);
  end

  // Output registers; reset parks at (0,0) with sync inactive and no pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      countH      <= 11'd0;
      countV      <= 11'd0;
      h_sinc      <= ~SYNC_ACT;
      v_sinc      <= ~SYNC_ACT;
      visible     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      countH      <= next_h_s;
      countV      <= next_v_s;
      h_sinc      <= h_act_s ? SYNC_ACT : ~SYNC_ACT;
      v_sinc      <= v_act_s ? SYNC_ACT : ~SYNC_ACT;
      visible     <= vis_s;
      line_start  <= line_s;
      frame_start <= frame_s;
    end
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates VGA horizontal/vertical sync and pixel coordinates for the display path, as the timing source that the on-screen clock-digit renderer and any other pixel generators consume. It runs from the single system clock, advances one pixel per `pix_en` strobe, and presents sync, coordinates, and visible-area flags as mutually coherent registered outputs. Default parameters give 640x480 @ 60 Hz with a 25 MHz pixel rate.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, active level of both sync outputs (0 = active-low)

Ports:
- `clk`  in  1  system clock; sole clock
- `rst`  in  1  reset, synchronous, active-high
- `pix_en`  in  1  pixel strobe; one pixel advance per `clk` with `pix_en`=1
- `h_sinc`  out  1  horizontal sync, polarity per `SYNC_POL`
- `v_sinc`  out  1  vertical sync, polarity per `SYNC_POL`
- `countH`  out  11  current pixel column, 0..H_TOTAL-1
- `countV`  out  11  current line, 0..V_TOTAL-1
- `visible`  out  1  1 when countH<H_VISIBLE and countV<V_VISIBLE
- `line_start`  out  1  one-`clk` pulse when countH becomes 0
- `frame_start`  out  1  one-`clk` pulse when (countH,countV) becomes (0,0)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both must be ≤2047; all arithmetic 11-bit unsigned, no other truncation.
- Horizontal counter: on `pix_en`, countH increments; at H_TOTAL-1 wraps to 0.
- Vertical counter: increments only on a `pix_en` cycle where countH wraps; at V_TOTAL-1 (with countH wrap) wraps to 0.
- h_sinc active iff H_VISIBLE+H_FRONT ≤ countH ≤ H_VISIBLE+H_FRONT+H_SYNC-1 (656..751 default).
- v_sinc active iff V_VISIBLE+V_FRONT ≤ countV ≤ V_VISIBLE+V_FRONT+V_SYNC-1 (490..491 default); v_sinc tracks countV only, so it changes on the same edge as countH wraps to 0.
- Active level = `SYNC_POL`; inactive level = ~`SYNC_POL`.
- All outputs are registers computed from next-state counter values, so sync, flags, and coordinates always describe the same pixel (zero skew between them).
- `pix_en`=0: every output except the pulses holds; `line_start`/`frame_start` are 0.
- `line_start`=1 on the single `clk` after the edge that loads countH=0; `frame_start` likewise for (0,0), and then `line_start` is also 1.

## Timing
- Reset (`rst`=1 at a `clk` edge, any state, regardless of `pix_en`): countH=0, countV=0, h_sinc=v_sinc=inactive, visible=1, line_start=0, frame_start=0. `rst` overrides `pix_en`.
- First `pix_en` after reset moves to countH=1; no start pulses are emitted for the reset-loaded (0,0).
- Latency: `pix_en` at edge N → new countH and all derived outputs valid after edge N; no further pipeline.
- Line period = H_TOTAL `pix_en` strobes; frame period = H_TOTAL·V_TOTAL strobes (420000 default).
- `pix_en` continuously 1 is legal (pixel rate = `clk`); irregular strobes stretch time but never skip or repeat a count.
- Reset mid-line or mid-sync: sync deasserts on that edge; no partial-pulse completion.

## Test plan
- Reset: drive `rst` 3 cycles mid-frame (countH=700, countV=491) → next cycle countH=0, countV=0, h_sinc=1, v_sinc=1, visible=1, pulses 0.
- Horizontal: `pix_en`=1 continuously from reset → h_sinc falls as countH 655→656, rises as countH 751→752, exactly 96 cycles low; countH wraps 799→0 with line_start=1 for 1 cycle, countV 0→1.
- Vertical: run full frame → v_sinc low exactly for countV 490 and 491 (1600 strobes), visible=0 for countV≥480 and countH≥640; frame_start pulses every 420000 strobes.
- Strobe gating: `pix_en` toggling 1/0 → every output holds during 0 cycles, line period = 1600 `clk`, no pulse on a `pix_en`=0 cycle.
- Polarity: `SYNC_POL`=1 → h_sinc high only for countH 656..751, v_sinc high only for countV 490..491, both 0 after reset.
- Small geometry: H=4/1/2/1, V=3/1/1/1 → countH cycles 0..7, countV 0..5, h_sinc active at countH 5..6, v_sinc active at countV 4.
